// File: rtl/qea_host_sequencer_if.sv
// qea_host_sequencer_if
//   Host-facing channels of the QEA host sequencer, grouped into one bundle.
//   Three channels, all following the same valid/ready rule:
//     A transfer happens on a rising clk edge where valid and ready are both
//     high. Once valid is raised, the source holds it and its payload
//     unchanged until that transfer edge. Ready may rise or fall at any
//     time and never depends on valid combinationally.
//   cmd : i_cmd_valid/o_cmd_ready with i_qbit_num, i_ins_num, i_basis_idx
//   ins : i_ins_valid/o_ins_ready with i_ins_data
//   res : o_res_valid/i_res_ready with o_res_data, o_res_last
//   modport slave  - the sequencer side
//   modport master - the host side
interface qea_host_sequencer_if #(
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int PE_NUM_WIDTH            = 2,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int RES_WIDTH               = 256
);
  logic                                 i_cmd_valid;
  logic                                 o_cmd_ready;
  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num;
  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num;
  logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] i_basis_idx;

  logic                                 i_ins_valid;
  logic                                 o_ins_ready;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ins_data;

  logic                                 o_res_valid;
  logic                                 i_res_ready;
  logic [RES_WIDTH-1:0]                 o_res_data;
  logic                                 o_res_last;

  modport slave (
    input  i_cmd_valid, i_qbit_num, i_ins_num, i_basis_idx,
    input  i_ins_valid, i_ins_data,
    input  i_res_ready,
    output o_cmd_ready, o_ins_ready,
    output o_res_valid, o_res_data, o_res_last
  );

  modport master (
    output i_cmd_valid, i_qbit_num, i_ins_num, i_basis_idx,
    output i_ins_valid, i_ins_data,
    output i_res_ready,
    input  o_cmd_ready, o_ins_ready,
    input  o_res_valid, o_res_data, o_res_last
  );
endinterface

// File: rtl/qea_host_sequencer.sv
// qea_host_sequencer
//   Host-side job sequencer for the quantum emulation accelerator (QEA).
//   One job: accept a command, stream the gate instructions into the QEA
//   context RAM, write the initial basis state into the state RAM, pulse the
//   QEA start, time the run until complete, then read every state row back
//   and hand it to the host over the result channel.
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : command, instruction and result channels
//   o_ctx_*           : context-RAM write port
//   o_state_*         : state-RAM port (writes during init, reads at the end)
//   i_state_dout      : state-RAM read data, READ_LATENCY cycles after a read
//   o_qea_start       : one-cycle start pulse; o_qbit_num is the job's q
//   i_qea_complete    : QEA finished
//   o_busy/o_done/o_err : status; o_done and o_err are one-cycle pulses
//   o_cycle_count     : RUN cycles of the last job (saturating)
//   o_dbg_state       : current FSM state encoding
module qea_host_sequencer #(
  parameter int PE_NUM                  = 4,
  parameter int PE_NUM_WIDTH            = 2,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int READ_LATENCY            = 1,
  parameter int CYCLE_CNT_WIDTH         = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  qea_host_sequencer_if.slave                bus,
  output logic                               o_ctx_en,
  output logic                               o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data,
  output logic                               o_state_ena,
  output logic                               o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_state_dina,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_state_dout,
  output logic                               o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]          o_qbit_num,
  input  logic                               i_qea_complete,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err,
  output logic [CYCLE_CNT_WIDTH-1:0]         o_cycle_count,
  output logic [3:0]                         o_dbg_state
);

  localparam int ROW_W   = PE_NUM*STATE_DATA_WIDTH;
  localparam int BASIS_W = STATE_ADDR_WIDTH+PE_NUM_WIDTH;
  localparam int CNT_W   = GATE_CONTEXT_ADDR_WIDTH+1;
  localparam int WAIT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [DATA_WIDTH-1:0] FIX_ONE = DATA_WIDTH'(1) << NUM_FRAC_BIT;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LOAD_CTX   = 4'd1,
    INIT_STATE = 4'd2,
    START      = 4'd3,
    RUN        = 4'd4,
    READ_REQ   = 4'd5,
    READ_WAIT  = 4'd6,
    READ_HOLD  = 4'd7,
    DONE       = 4'd8
  } state_t;

  state_t                               state_q;
  logic                                 cmd_ready_q, ins_ready_q;
  logic                                 ctx_en_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_addr_q;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_data_q;
  logic                                 st_ena_q, st_wea_q;
  logic [STATE_ADDR_WIDTH-1:0]          st_addr_q;
  logic [ROW_W-1:0]                     st_dina_q;
  logic                                 start_q, busy_q, done_q, err_q;
  logic [MAX_QBIT_WIDTH-1:0]            qbit_q;
  logic [CNT_W-1:0]                     ins_num_q, ins_cnt_q;
  logic [BASIS_W-1:0]                   basis_q;
  logic [STATE_ADDR_WIDTH-1:0]          last_row_q, row_q;
  logic [WAIT_W-1:0]                    wait_cnt_q;
  logic                                 run_first_q;
  logic [CYCLE_CNT_WIDTH-1:0]           cyc_q;
  logic                                 res_valid_q, res_last_q;
  logic [ROW_W-1:0]                     res_data_q;

  // Combinational helpers
  logic                                 cmd_legal_d;
  logic [STATE_ADDR_WIDTH:0]            rows_d, last_row_full_d;
  logic [CNT_W-1:0]                     ins_cnt_d;
  logic [STATE_ADDR_WIDTH-1:0]          row_d;
  logic [CYCLE_CNT_WIDTH-1:0]           cyc_d;
  int                                   basis_lsb_d;

  always_comb begin
    // basis_idx >= 2^q is detected as any bit surviving a right shift by q.
    cmd_legal_d = 1'b1;
    if (bus.i_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH))                   cmd_legal_d = 1'b0;
    if (bus.i_qbit_num > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH+PE_NUM_WIDTH))  cmd_legal_d = 1'b0;
    if (bus.i_ins_num == '0)                                              cmd_legal_d = 1'b0;
    if (bus.i_ins_num[CNT_W-1] && (|bus.i_ins_num[CNT_W-2:0]))            cmd_legal_d = 1'b0;
    if ((bus.i_basis_idx >> bus.i_qbit_num) != '0)                        cmd_legal_d = 1'b0;
    rows_d          = (STATE_ADDR_WIDTH+1)'(1) << (bus.i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH));
    last_row_full_d = rows_d - (STATE_ADDR_WIDTH+1)'(1);
    ins_cnt_d       = ins_cnt_q + CNT_W'(1);
    row_d           = row_q + STATE_ADDR_WIDTH'(1);
    cyc_d           = cyc_q + CYCLE_CNT_WIDTH'(1);
    // Amplitude j sits in slot PE_NUM-1-(j mod PE_NUM); its real part is the
    // upper DATA_WIDTH bits of that slot.
    basis_lsb_d = (PE_NUM-1-int'(basis_q[PE_NUM_WIDTH-1:0]))*STATE_DATA_WIDTH + DATA_WIDTH;
  end

  function automatic logic [ROW_W-1:0] init_row(input logic [STATE_ADDR_WIDTH-1:0] row,
                                                 input logic [STATE_ADDR_WIDTH-1:0] basis_row,
                                                 input int lsb);
    logic [ROW_W-1:0] w;
    w = '0;
    if (row == basis_row) w[lsb +: DATA_WIDTH] = FIX_ONE;
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      ins_ready_q <= 1'b0;
      ctx_en_q    <= 1'b0;
      ctx_addr_q  <= '0;
      ctx_data_q  <= '0;
      st_ena_q    <= 1'b0;
      st_wea_q    <= 1'b0;
      st_addr_q   <= '0;
      st_dina_q   <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      qbit_q      <= '0;
      ins_num_q   <= '0;
      ins_cnt_q   <= '0;
      basis_q     <= '0;
      last_row_q  <= '0;
      row_q       <= '0;
      wait_cnt_q  <= '0;
      run_first_q <= 1'b0;
      cyc_q       <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
    end else begin
      // One-cycle pulses default low every cycle.
      ctx_en_q <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_cmd_valid && cmd_ready_q) begin
            if (!cmd_legal_d) begin
              err_q <= 1'b1;
            end else begin
              qbit_q      <= bus.i_qbit_num;
              ins_num_q   <= bus.i_ins_num;
              basis_q     <= bus.i_basis_idx;
              last_row_q  <= last_row_full_d[STATE_ADDR_WIDTH-1:0];
              ins_cnt_q   <= '0;
              cmd_ready_q <= 1'b0;
              ins_ready_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= LOAD_CTX;
            end
          end
        end
        LOAD_CTX: begin
          if (bus.i_ins_valid && ins_ready_q) begin
            ctx_en_q   <= 1'b1;
            ctx_addr_q <= ins_cnt_q[GATE_CONTEXT_ADDR_WIDTH-1:0];
            ctx_data_q <= bus.i_ins_data;
            ins_cnt_q  <= ins_cnt_d;
            if (ins_cnt_d == ins_num_q) begin
              // Row 0 write is presented in the first INIT_STATE cycle.
              ins_ready_q <= 1'b0;
              row_q       <= '0;
              st_ena_q    <= 1'b1;
              st_wea_q    <= 1'b1;
              st_addr_q   <= '0;
              st_dina_q   <= init_row('0, basis_q[BASIS_W-1:PE_NUM_WIDTH], basis_lsb_d);
              state_q     <= INIT_STATE;
            end
          end
        end
        INIT_STATE: begin
          if (row_q == last_row_q) begin
            st_ena_q  <= 1'b0;
            st_wea_q  <= 1'b0;
            st_dina_q <= '0;
            start_q   <= 1'b1;
            state_q   <= START;
          end else begin
            row_q     <= row_d;
            st_addr_q <= row_d;
            st_dina_q <= init_row(row_d, basis_q[BASIS_W-1:PE_NUM_WIDTH], basis_lsb_d);
          end
        end
        START: begin
          cyc_q       <= CYCLE_CNT_WIDTH'(1);
          run_first_q <= 1'b1;
          state_q     <= RUN;
        end
        RUN: begin
          run_first_q <= 1'b0;
          // A complete seen in the first RUN cycle is a leftover from the
          // previous job and is ignored.
          if (!run_first_q && i_qea_complete) begin
            row_q     <= '0;
            st_addr_q <= '0;
            st_ena_q  <= 1'b1;
            st_wea_q  <= 1'b0;
            state_q   <= READ_REQ;
          end else if (cyc_q != '1) begin
            cyc_q <= cyc_d;
          end
        end
        READ_REQ: begin
          st_ena_q   <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= READ_WAIT;
        end
        READ_WAIT: begin
          if (wait_cnt_q == WAIT_W'(READ_LATENCY-1)) begin
            res_data_q  <= i_state_dout;
            res_valid_q <= 1'b1;
            res_last_q  <= (row_q == last_row_q);
            state_q     <= READ_HOLD;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        READ_HOLD: begin
          if (bus.i_res_ready) begin
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            if (row_q != last_row_q) begin
              row_q     <= row_d;
              st_addr_q <= row_d;
              st_ena_q  <= 1'b1;
              st_wea_q  <= 1'b0;
              state_q   <= READ_REQ;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          cmd_ready_q <= 1'b1;
          ins_ready_q <= 1'b0;
          st_ena_q    <= 1'b0;
          st_wea_q    <= 1'b0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_cmd_ready = cmd_ready_q;
  assign bus.o_ins_ready = ins_ready_q;
  assign bus.o_res_valid = res_valid_q;
  assign bus.o_res_data  = res_data_q;
  assign bus.o_res_last  = res_last_q;

  assign o_ctx_en      = ctx_en_q;
  assign o_ctx_wea     = ctx_en_q;
  assign o_ctx_addr    = ctx_addr_q;
  assign o_ctx_data    = ctx_data_q;
  assign o_state_ena   = st_ena_q;
  assign o_state_wea   = st_wea_q;
  assign o_state_addra = st_addr_q;
  assign o_state_dina  = st_dina_q;
  assign o_qea_start   = start_q;
  assign o_qbit_num    = qbit_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_cycle_count = cyc_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_qea_host_sequencer.sv
module tb_qea_host_sequencer;

  localparam int ROW_W = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qea_host_sequencer_if #(
    .MAX_QBIT_WIDTH(6), .STATE_ADDR_WIDTH(16), .PE_NUM_WIDTH(2),
    .GATE_CONTEXT_ADDR_WIDTH(16), .GATE_CONTEXT_DATA_WIDTH(64), .RES_WIDTH(ROW_W)
  ) bus ();

  logic              ctx_en, ctx_wea;
  logic [15:0]       ctx_addr;
  logic [63:0]       ctx_data;
  logic              state_ena, state_wea;
  logic [15:0]       state_addra;
  logic [ROW_W-1:0]  state_dina;
  logic [ROW_W-1:0]  dout_q = '0;
  logic              qea_start;
  logic [5:0]        qbit_num;
  logic              qea_complete = 1'b0;
  logic              busy, done, err;
  logic [31:0]       cycle_count;
  logic [3:0]        dbg_state;

  qea_host_sequencer dut (
    .clk(clk), .rst(rst), .bus(bus),
    .o_ctx_en(ctx_en), .o_ctx_wea(ctx_wea), .o_ctx_addr(ctx_addr), .o_ctx_data(ctx_data),
    .o_state_ena(state_ena), .o_state_wea(state_wea), .o_state_addra(state_addra),
    .o_state_dina(state_dina), .i_state_dout(dout_q),
    .o_qea_start(qea_start), .o_qbit_num(qbit_num), .i_qea_complete(qea_complete),
    .o_busy(busy), .o_done(done), .o_err(err), .o_cycle_count(cycle_count),
    .o_dbg_state(dbg_state)
  );

  // State RAM stand-in: reads return the rows the "QEA" produced, 1-cycle latency.
  logic [ROW_W-1:0] qea_res[16];
  always @(posedge clk) begin
    if (state_ena) dout_q <= qea_res[state_addra[3:0]];
  end

  // ---------------- monitor ----------------
  logic [80:0]  ctx_log[$];
  logic [271:0] wr_log[$];
  logic [15:0]  rd_log[$];
  int start_cnt = 0, err_cnt = 0, hold_rd_viol = 0, stable_viol = 0;
  logic prev_hold = 1'b0;
  logic [ROW_W-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (ctx_en) ctx_log.push_back({ctx_wea, ctx_addr, ctx_data});
    if (state_ena && state_wea) wr_log.push_back({state_addra, state_dina});
    if (state_ena && !state_wea) rd_log.push_back(state_addra);
    if (qea_start) start_cnt++;
    if (err) err_cnt++;
    if (bus.o_res_valid && state_ena) hold_rd_viol++;
    if (prev_hold && bus.o_res_valid && (bus.o_res_data !== prev_data)) stable_viol++;
    prev_hold = bus.o_res_valid && !bus.i_res_ready;
    prev_data = bus.o_res_data;
  end

  // ---------------- scoreboard ----------------
  logic [ROW_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] ins_word(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 ^ 32'(i)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [5:0] q, input logic [16:0] n, input logic [17:0] b);
    int t = 0;
    @(negedge clk);
    while (!bus.o_cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (t == 50) check("cmd_ready_timeout", 0, 1);
    bus.i_cmd_valid = 1'b1; bus.i_qbit_num = q; bus.i_ins_num = n; bus.i_basis_idx = b;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic send_ins(input int count, input bit gapped);
    for (int i = 0; i < count; i++) begin
      int t = 0;
      int g = gapped ? i + (i > 0 ? 1 : 0) : 0;
      repeat (g) begin @(posedge clk); #1; end
      bus.i_ins_valid = 1'b1; bus.i_ins_data = ins_word(i);
      while (!bus.o_ins_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (t == 50) check("ins_ready_timeout", 0, 1);
      @(posedge clk); #1;
      bus.i_ins_valid = 1'b0;
    end
  endtask

  // complete is high in RUN cycle 1 (must be ignored), low, then high in cycle n.
  task automatic run_qea(input int n, input logic [5:0] q);
    int t = 0;
    @(negedge clk);
    while (!qea_start && t < 300) begin @(negedge clk); t++; end
    check("start_seen", qea_start, 1);
    @(posedge clk); #1 qea_complete = 1'b1;
    check("run_qbit_num", qbit_num, q);
    check("run_busy", busy, 1);
    @(posedge clk); #1 qea_complete = 1'b0;
    repeat (n-2) @(posedge clk);
    #1 qea_complete = 1'b1;
    @(posedge clk); #1 qea_complete = 1'b0;
  endtask

  task automatic collect(input int rows, input int stall_row, input int stall_n);
    logic [ROW_W-1:0] e;
    int t;
    for (int i = 0; i < rows; i++) begin
      t = 0;
      @(negedge clk);
      while (!bus.o_res_valid && t < 50) begin @(negedge clk); t++; end
      e = exp_q.pop_front();
      check("res_data", bus.o_res_data, e);
      check("res_last", bus.o_res_last, (i == rows-1));
      if (i == stall_row) begin
        repeat (stall_n) @(negedge clk);
        check("res_hold_valid", bus.o_res_valid, 1);
        check("res_hold_data", bus.o_res_data, e);
      end
      bus.i_res_ready = 1'b1;
      @(posedge clk); #1 bus.i_res_ready = 1'b0;
    end
    t = 0;
    @(negedge clk);
    while (!done && t < 10) begin @(negedge clk); t++; end
    check("done_pulse", done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after_done", bus.o_cmd_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  int cb, wb, rb, sb, eb, hb, stb;
  logic [271:0] w;
  logic [ROW_W-1:0] row_img;

  task automatic snap();
    cb = ctx_log.size(); wb = wr_log.size(); rb = rd_log.size();
    sb = start_cnt; eb = err_cnt; hb = hold_rd_viol; stb = stable_viol;
  endtask

  initial begin
    bus.i_cmd_valid = 1'b0; bus.i_qbit_num = '0; bus.i_ins_num = '0; bus.i_basis_idx = '0;
    bus.i_ins_valid = 1'b0; bus.i_ins_data = '0; bus.i_res_ready = 1'b0;
    for (int i = 0; i < 16; i++) qea_res[i] = {8{32'hF00D_0000 + 32'(i)}};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", bus.o_cmd_ready, 1);
    check("rst_ins_ready", bus.o_ins_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_ctx_en", ctx_en, 0);
    check("rst_state_ena", state_ena, 0);
    check("rst_res_valid", bus.o_res_valid, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_state", dbg_state, 0);

    // Job 1: q=5, 3 instructions, basis 0, complete in RUN cycle 12, stall row 2.
    snap();
    send_cmd(6'd5, 17'd3, 18'd0);
    send_ins(3, 1'b0);
    run_qea(12, 6'd5);
    @(negedge clk);
    check("t1_cycle_count", cycle_count, 32'd12);
    for (int i = 0; i < 8; i++) exp_q.push_back(qea_res[i]);
    collect(8, 2, 5);
    check("t1_ctx_count", ctx_log.size() - cb, 3);
    for (int i = 0; i < 3; i++) check("t1_ctx_write", ctx_log[cb+i], {1'b1, 16'(i), ins_word(i)});
    check("t1_wr_count", wr_log.size() - wb, 8);
    for (int i = 0; i < 8; i++) begin
      w = wr_log[wb+i];
      row_img = '0;
      if (i == 0) row_img[255:192] = 64'h40000000_00000000;
      check("t1_wr_addr", w[271:256], i);
      check("t1_wr_data", w[255:0], row_img);
    end
    check("t1_rd_count", rd_log.size() - rb, 8);
    for (int i = 0; i < 8; i++) check("t1_rd_addr", rd_log[rb+i], i);
    check("t1_start_count", start_cnt - sb, 1);
    check("t1_no_read_in_hold", hold_rd_viol - hb, 0);
    check("t1_res_stable", stable_viol - stb, 0);
    check("t1_no_err", err_cnt - eb, 0);

    // Job 2: basis 6 -> row 1, slot 1.
    for (int i = 0; i < 16; i++) qea_res[i] = {8{32'hBEEF_0000 ^ 32'(i*17)}};
    snap();
    send_cmd(6'd5, 17'd1, 18'd6);
    send_ins(1, 1'b0);
    run_qea(3, 6'd5);
    @(negedge clk);
    check("t2_cycle_count", cycle_count, 32'd3);
    for (int i = 0; i < 8; i++) exp_q.push_back(qea_res[i]);
    collect(8, -1, 0);
    check("t2_wr_count", wr_log.size() - wb, 8);
    for (int i = 0; i < 8; i++) begin
      w = wr_log[wb+i];
      row_img = '0;
      if (i == 1) row_img[127:64] = 64'h40000000_00000000;
      check("t2_wr_data", w[255:0], row_img);
    end

    // Illegal commands: q too small, ins_num 0, basis out of range, q too big, ins_num too big.
    snap();
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: send_cmd(6'd1,  17'd3,       18'd0);
        1: send_cmd(6'd5,  17'd0,       18'd0);
        2: send_cmd(6'd3,  17'd1,       18'd8);
        3: send_cmd(6'd19, 17'd1,       18'd0);
        default: send_cmd(6'd5, 17'h10001, 18'd0);
      endcase
      @(negedge clk);
      check("ill_err", err, 1);
      check("ill_cmd_ready", bus.o_cmd_ready, 1);
      check("ill_busy", busy, 0);
      @(negedge clk);
      check("ill_err_one_cycle", err, 0);
    end
    check("ill_no_ctx", ctx_log.size() - cb, 0);
    check("ill_no_state", wr_log.size() - wb + rd_log.size() - rb, 0);
    check("ill_no_start", start_cnt - sb, 0);

    // Gapped instructions then reset mid-LOAD_CTX.
    snap();
    send_cmd(6'd5, 17'd4, 18'd0);
    send_ins(3, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("gap_still_loading", bus.o_ins_ready, 1);
    check("gap_ctx_count", ctx_log.size() - cb, 3);
    for (int i = 0; i < 3; i++) check("gap_ctx_write", ctx_log[cb+i], {1'b1, 16'(i), ins_word(i)});
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_cmd_ready", bus.o_cmd_ready, 1);
    check("rst2_ins_ready", bus.o_ins_ready, 0);
    check("rst2_busy", busy, 0);
    check("rst2_cycle_count", cycle_count, 0);
    check("rst2_qbit_num", qbit_num, 0);
    check("rst2_state", dbg_state, 0);

    // Smallest legal job after reset: q=2 (one row), basis 3 -> slot 0.
    snap();
    send_cmd(6'd2, 17'd1, 18'd3);
    send_ins(1, 1'b0);
    run_qea(2, 6'd2);
    @(negedge clk);
    check("t4_cycle_count", cycle_count, 32'd2);
    exp_q.push_back(qea_res[0]);
    collect(1, -1, 0);
    check("t4_ctx_count", ctx_log.size() - cb, 1);
    check("t4_ctx_write", ctx_log[cb], {1'b1, 16'd0, ins_word(0)});
    check("t4_wr_count", wr_log.size() - wb, 1);
    w = wr_log[wb];
    check("t4_wr_row", w, {16'd0, 256'h40000000_00000000});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qea_host_sequencer.md
QEA_HOST_SEQUENCER -- requirements
Module: qea_host_sequencer

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- PE_NUM, 4, PE lanes per state row (power of 2).
- PE_NUM_WIDTH, 2, log2(PE_NUM).
- DATA_WIDTH, 32, fixed-point word.
- STATE_DATA_WIDTH, 2*DATA_WIDTH, complex amplitude {re,im}.
- STATE_ADDR_WIDTH, 16, state row address.
- GATE_CONTEXT_DATA_WIDTH, 64, instruction word.
- GATE_CONTEXT_ADDR_WIDTH, 16, context address.
- MAX_QBIT_WIDTH, 6, qubit-count field.
- NUM_FRAC_BIT, 30, fraction bits.
- READ_LATENCY, 1, state-RAM read latency in cycles (>=1).
- CYCLE_CNT_WIDTH, 32, run-cycle counter width.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, reset, synchronous, active-high.
- i_cmd_valid / o_cmd_ready, in / out, 1 each, command handshake.
- i_qbit_num, in, MAX_QBIT_WIDTH, qubit count q.
- i_ins_num, in, GATE_CONTEXT_ADDR_WIDTH+1, instruction count.
- i_basis_idx, in, STATE_ADDR_WIDTH+PE_NUM_WIDTH, initial basis state.
- i_ins_valid / o_ins_ready, in / out, 1 each, instruction stream handshake.
- i_ins_data, in, GATE_CONTEXT_DATA_WIDTH, instruction word.
- o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data, out, 1 / 1 / GATE_CONTEXT_ADDR_WIDTH / GATE_CONTEXT_DATA_WIDTH, QEA context-RAM port.
- o_state_ena, o_state_wea, out, 1 each, QEA state-RAM enable and write enable.
- o_state_addra, out, STATE_ADDR_WIDTH, QEA state-RAM address.
- o_state_dina, out, PE_NUM*STATE_DATA_WIDTH, QEA state-RAM write data.
- i_state_dout, in, PE_NUM*STATE_DATA_WIDTH, QEA state-RAM read data.
- o_qea_start, out, 1, QEA start pulse.
- o_qbit_num, out, MAX_QBIT_WIDTH, latched q.
- i_qea_complete, in, 1, QEA complete.
- o_res_valid / i_res_ready, out / in, 1 each, result handshake.
- o_res_data, out, PE_NUM*STATE_DATA_WIDTH, one result row.
- o_res_last, out, 1, marks final result row.
- o_busy, out, 1, high when not IDLE.
- o_done, out, 1, done pulse.
- o_err, out, 1, error pulse.
- o_cycle_count, out, CYCLE_CNT_WIDTH, measured run cycles.

Function
REQ-003 States SHALL be IDLE, LOAD_CTX, INIT_STATE, START, RUN, READ_REQ, READ_WAIT, READ_HOLD, DONE; o_cmd_ready=1 only in IDLE.
REQ-004 Command accept (valid&ready) SHALL latch q, ins_num and basis_idx; ROWS=2^(q-PE_NUM_WIDTH).
REQ-005 Command SHALL be illegal if q<PE_NUM_WIDTH, q>STATE_ADDR_WIDTH+PE_NUM_WIDTH, ins_num=0, ins_num>2^GATE_CONTEXT_ADDR_WIDTH, or basis_idx>=2^q; illegal -> o_err high one cycle, no RAM/start activity, stay IDLE.
REQ-006 Legal command SHALL enter LOAD_CTX; o_ins_ready=1 only there.
REQ-007 Each instruction handshake at edge N SHALL drive o_ctx_en=o_ctx_wea=1, o_ctx_addr=k (k=0,1,...), o_ctx_data=word for the cycle after N; cycles without a handshake SHALL have o_ctx_en=o_ctx_wea=0.
REQ-008 After the ins_num-th handshake the block SHALL enter INIT_STATE.
REQ-009 INIT_STATE SHALL write rows 0..ROWS-1, one per cycle, with o_state_ena=o_state_wea=1.
REQ-010 Amplitude j SHALL live at row j>>PE_NUM_WIDTH, slot PE_NUM-1-(j mod PE_NUM); slot s occupies bits [(s+1)*STATE_DATA_WIDTH-1 : s*STATE_DATA_WIDTH].
REQ-011 Basis amplitude SHALL be re=1<<NUM_FRAC_BIT in the upper DATA_WIDTH, im=0; all other slots SHALL be 0.
REQ-012 START SHALL last one cycle with o_qea_start=1; o_qbit_num SHALL hold latched q from accept until IDLE.
REQ-013 o_cycle_count SHALL load 1 on entering RUN and increment on each later RUN cycle; it holds its value outside RUN until the next RUN, and saturates at all-ones.
REQ-014 i_qea_complete SHALL be ignored in the first RUN cycle; when sampled high afterwards the block SHALL go to READ_REQ with row r=0.
REQ-015 READ_REQ SHALL last one cycle: o_state_ena=1, o_state_wea=0, o_state_addra=r; READ_WAIT SHALL last READ_LATENCY cycles, then i_state_dout SHALL be captured into o_res_data.
REQ-016 READ_HOLD SHALL assert o_res_valid with o_res_data stable until i_res_ready; o_res_last=1 iff r=ROWS-1; no read SHALL be issued while holding.
REQ-017 On accept, r<ROWS-1 -> READ_REQ with r+1; else DONE.
REQ-018 DONE SHALL pulse o_done one cycle, then go to IDLE.
REQ-019 Write/enable outputs SHALL be 0 in every state and cycle not listed above.

Reset
REQ-020 rst sampled high SHALL force IDLE from any state; all outputs SHALL be 0 except o_cmd_ready=1; latched fields, counters and o_cycle_count SHALL be cleared.
REQ-021 Reset mid-operation SHALL abandon the job; the next command SHALL restart at context address 0.

Verification
REQ-022 PE_NUM=4, q=5, ins_num=3, basis 0 -> ctx writes at addresses 0,1,2 with matching data; 8 state writes; row 0 dina[255:192]=0x40000000_00000000, all else 0; one o_qea_start pulse.
REQ-023 basis_idx=6, q=5 -> only row 1, slot 1 (bits [127:64]) = 0x40000000_00000000.
REQ-024 i_qea_complete high at RUN entry, low, then high in the 12th RUN cycle -> o_cycle_count=12, first read at row 0.
REQ-025 i_res_ready low 5 cycles at row 2 -> o_res_data stable, no o_state_ena, o_res_last only on row 7, o_done after.
REQ-026 q=1 with PE_NUM=4, or ins_num=0 -> one-cycle o_err, no writes, o_cmd_ready=1 next cycle.
REQ-027 Gapped i_ins_valid, then rst mid-LOAD_CTX -> contiguous addresses with no writes in gaps; after reset outputs are 0 and a new command writes from address 0.
